// File: rtl/fetch_trace_checker.sv
// Checks stage0 PC updates and epoch toggles against the permitted next-state rules,
// queueing violation records in a small FIFO that a consumer drains over valid/ready.
module fetch_trace_checker #(
  parameter int XLEN          = 64,
  parameter int DEPTH         = 8,
  parameter bit STOP_ON_ERROR = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            clear,
  input  logic [XLEN-1:0] rg_pc,
  input  logic            rg_pc_en,
  input  logic [XLEN-1:0] rg_pc_d_in,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            bpu_taken,
  input  logic [XLEN-1:0] bpu_target,
  input  logic            en_update_eepoch,
  input  logic            en_update_wepoch,
  input  logic            rg_eepoch,
  input  logic            rg_wepoch,
  output logic            err_valid,
  input  logic            err_ready,
  output logic [2:0]      err_code,
  output logic [XLEN-1:0] err_pc,
  output logic            err_overflow,
  output logic [15:0]     error_count,
  output logic [31:0]     pc_update_count,
  output logic [1:0]      state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    RUN        = 2'd1,
    STOPPED    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   run;

  assign run   = (state_q == RUN);
  assign state = state_q;

  // Registered epoch toggle requests and the epoch value they were issued against
  logic ee_req_q, ee_old_q, we_req_q, we_old_q;

  logic [XLEN-1:0] seq_pc, legal_pc;
  logic            bad_pc, bad_ee, bad_we, misalign, detect;
  logic [2:0]      det_code;

  assign seq_pc = {rg_pc[XLEN-1:2] + (XLEN-2)'(1), 2'b00};

  always_comb begin
    legal_pc = seq_pc;
    if (flush_valid)    legal_pc = flush_pc;
    else if (bpu_taken) legal_pc = bpu_target;
  end

  assign bad_pc   = run & rg_pc_en & (rg_pc_d_in != legal_pc);
  assign misalign = run & rg_pc_en & rg_pc_d_in[0];
  assign bad_ee   = run & ee_req_q & (rg_eepoch == ee_old_q);
  assign bad_we   = run & we_req_q & (rg_wepoch == we_old_q);

  // Several simultaneous violations collapse into one record carrying the lowest code
  always_comb begin
    det_code = 3'd0;
    if (bad_pc)        det_code = 3'd1;
    else if (bad_ee)   det_code = 3'd2;
    else if (bad_we)   det_code = 3'd3;
    else if (misalign) det_code = 3'd4;
  end

  assign detect = (det_code != 3'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FIRST: if (rg_pc_en) state_d = RUN;
      RUN:        if (detect && STOP_ON_ERROR) state_d = STOPPED;
      STOPPED:    state_d = STOPPED;
      default:    state_d = WAIT_FIRST;
    endcase
    if (clear) state_d = WAIT_FIRST;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= WAIT_FIRST;
    else        state_q <= state_d;
  end

  // Drain port: the head is popped on any cycle with err_valid & err_ready both high;
  // err_code/err_pc hold their value while err_valid is high and err_ready is low.
  logic [2:0]      mem_code [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, pop, push;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign err_valid = !empty;
  assign pop       = err_valid & err_ready;
  assign push      = detect & (!full | pop);
  assign err_code  = err_valid ? mem_code[rd_ptr[AW-1:0]] : 3'd0;
  assign err_pc    = err_valid ? mem_pc[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge CLK) begin
    if (!clear && push) begin
      mem_code[wr_ptr[AW-1:0]] <= det_code;
      mem_pc[wr_ptr[AW-1:0]]   <= rg_pc;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      err_overflow    <= 1'b0;
      error_count     <= 16'd0;
      pc_update_count <= 32'd0;
      ee_req_q        <= 1'b0;
      ee_old_q        <= 1'b0;
      we_req_q        <= 1'b0;
      we_old_q        <= 1'b0;
    end else if (clear) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      err_overflow    <= 1'b0;
      error_count     <= 16'd0;
      pc_update_count <= 32'd0;
      ee_req_q        <= 1'b0;
      ee_old_q        <= 1'b0;
      we_req_q        <= 1'b0;
      we_old_q        <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (detect && full && !pop) err_overflow <= 1'b1;
      if (detect && (error_count != 16'hFFFF)) error_count <= error_count + 16'd1;
      if (run && rg_pc_en) pc_update_count <= pc_update_count + 32'd1;
      // Requests only arm a check when issued in RUN; the check fires only if still in RUN
      ee_req_q <= run & en_update_eepoch;
      ee_old_q <= rg_eepoch;
      we_req_q <= run & en_update_wepoch;
      we_old_q <= rg_wepoch;
    end
  end

endmodule

// File: tb/tb_fetch_trace_checker.sv
// Bench for fetch_trace_checker: two instances (stop-on-error and free-running) share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_fetch_trace_checker;

  localparam int XLEN  = 64;
  localparam int DEPTH = 8;

  logic            CLK, RST_N, clear;
  logic [XLEN-1:0] rg_pc, rg_pc_d_in, flush_pc, bpu_target;
  logic            rg_pc_en, flush_valid, bpu_taken;
  logic            en_update_eepoch, en_update_wepoch, rg_eepoch, rg_wepoch;
  logic            err_ready;

  logic [1:0]      o_valid, o_ovf;
  logic [2:0]      o_code  [2];
  logic [XLEN-1:0] o_pc    [2];
  logic [15:0]     o_errs  [2];
  logic [31:0]     o_upd   [2];
  logic [1:0]      o_state [2];

  fetch_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .STOP_ON_ERROR(1'b1)) u_stop (
    .CLK(CLK), .RST_N(RST_N), .clear(clear), .rg_pc(rg_pc), .rg_pc_en(rg_pc_en),
    .rg_pc_d_in(rg_pc_d_in), .flush_valid(flush_valid), .flush_pc(flush_pc),
    .bpu_taken(bpu_taken), .bpu_target(bpu_target), .en_update_eepoch(en_update_eepoch),
    .en_update_wepoch(en_update_wepoch), .rg_eepoch(rg_eepoch), .rg_wepoch(rg_wepoch),
    .err_valid(o_valid[0]), .err_ready(err_ready), .err_code(o_code[0]), .err_pc(o_pc[0]),
    .err_overflow(o_ovf[0]), .error_count(o_errs[0]), .pc_update_count(o_upd[0]),
    .state(o_state[0]));

  fetch_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .STOP_ON_ERROR(1'b0)) u_run (
    .CLK(CLK), .RST_N(RST_N), .clear(clear), .rg_pc(rg_pc), .rg_pc_en(rg_pc_en),
    .rg_pc_d_in(rg_pc_d_in), .flush_valid(flush_valid), .flush_pc(flush_pc),
    .bpu_taken(bpu_taken), .bpu_target(bpu_target), .en_update_eepoch(en_update_eepoch),
    .en_update_wepoch(en_update_wepoch), .rg_eepoch(rg_eepoch), .rg_wepoch(rg_wepoch),
    .err_valid(o_valid[1]), .err_ready(err_ready), .err_code(o_code[1]), .err_pc(o_pc[1]),
    .err_overflow(o_ovf[1]), .error_count(o_errs[1]), .pc_update_count(o_upd[1]),
    .state(o_state[1]));

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int cyc     = 0;

  // Reference model: index 0 stops on error, index 1 keeps running
  logic [XLEN+2:0] exp_q0[$];
  logic [XLEN+2:0] exp_q1[$];
  int          m_state [2];
  bit          m_pend_e[2], m_old_e[2], m_pend_w[2], m_old_w[2], m_ovf[2];
  int unsigned m_errs  [2];
  logic [31:0] m_upd   [2];

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [XLEN+2:0] qhead(input int k);
    logic [XLEN+2:0] h;
    h = '0;
    if (k == 0 && exp_q0.size() > 0) h = exp_q0[0];
    if (k == 1 && exp_q1.size() > 0) h = exp_q1[0];
    return h;
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic qpush(input int k, input logic [XLEN+2:0] rec);
    if (k == 0) exp_q0.push_back(rec);
    else        exp_q1.push_back(rec);
  endtask

  task automatic model_clear(input int k);
    if (k == 0) exp_q0.delete();
    else        exp_q1.delete();
    m_state[k] = 0; m_pend_e[k] = 0; m_old_e[k] = 0; m_pend_w[k] = 0; m_old_w[k] = 0;
    m_ovf[k] = 0; m_errs[k] = 0; m_upd[k] = 32'd0;
  endtask

  task automatic model_update(input int k);
    logic [XLEN-1:0] legal;
    bit run, c1, c2, c3, c4, pop;
    int code, sz;
    if (clear) model_clear(k);
    else begin
      run   = (m_state[k] == 1);
      legal = flush_valid ? flush_pc : (bpu_taken ? bpu_target : ((rg_pc >> 2) + 64'd1) << 2);
      c1 = run && rg_pc_en && (rg_pc_d_in != legal);
      c2 = run && m_pend_e[k] && (rg_eepoch == m_old_e[k]);
      c3 = run && m_pend_w[k] && (rg_wepoch == m_old_w[k]);
      c4 = run && rg_pc_en && rg_pc_d_in[0];
      code = c1 ? 1 : c2 ? 2 : c3 ? 3 : c4 ? 4 : 0;
      sz  = qsize(k);
      pop = (sz > 0) && err_ready;
      if (pop) qpop(k);
      if (code != 0) begin
        if (sz < DEPTH || pop) qpush(k, {3'(code), rg_pc});
        else m_ovf[k] = 1;
        if (m_errs[k] < 65535) m_errs[k]++;
      end
      if (run && rg_pc_en) m_upd[k] = m_upd[k] + 32'd1;
      m_pend_e[k] = run && en_update_eepoch; m_old_e[k] = rg_eepoch;
      m_pend_w[k] = run && en_update_wepoch; m_old_w[k] = rg_wepoch;
      if (m_state[k] == 0 && rg_pc_en) m_state[k] = 1;
      else if (run && code != 0 && k == 0) m_state[k] = 2;
    end
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s @cyc%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [XLEN+2:0] h;
      bit ne;
      ne = (qsize(k) > 0);
      h  = qhead(k);
      check($sformatf("state%0d", k), 64'(o_state[k]), 64'(m_state[k]));
      check($sformatf("valid%0d", k), 64'(o_valid[k]), 64'(ne));
      check($sformatf("code%0d", k), 64'(o_code[k]), ne ? 64'(h[XLEN+2:XLEN]) : 64'd0);
      check($sformatf("pc%0d", k), o_pc[k], ne ? h[XLEN-1:0] : 64'd0);
      check($sformatf("ovf%0d", k), 64'(o_ovf[k]), 64'(m_ovf[k]));
      check($sformatf("errs%0d", k), 64'(o_errs[k]), 64'(m_errs[k]));
      check($sformatf("upd%0d", k), 64'(o_upd[k]), 64'(m_upd[k]));
    end
  endtask

  // Driver tasks
  task automatic step();
    model_update(0);
    model_update(1);
    @(posedge CLK);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic idle();
    clear = 0; rg_pc_en = 0; flush_valid = 0; bpu_taken = 0;
    en_update_eepoch = 0; en_update_wepoch = 0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_clear(0);
    model_clear(1);
    #1;
    compare_all();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic enter_run(input logic [XLEN-1:0] pc);
    idle(); clear = 1; step();
    clear = 0; rg_pc_en = 1; rg_pc_d_in = pc; step();
    idle();
  endtask

  task automatic pc_upd(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] d);
    rg_pc = pc; rg_pc_d_in = d; rg_pc_en = 1; step(); rg_pc_en = 0;
  endtask

  logic [XLEN-1:0] cur_pc, legal;
  bit              prev_e, prev_w;
  int              mode;

  initial begin
    RST_N = 1'b1; idle(); err_ready = 0;
    rg_pc = '0; rg_pc_d_in = '0; flush_pc = '0; bpu_target = '0;
    rg_eepoch = 0; rg_wepoch = 0;
    #3;
    do_reset();
    check("rst_state", 64'(o_state[0]), 64'd0);

    // First update leaves WAIT_FIRST uncounted, then one sequential update
    rg_pc_en = 1; rg_pc_d_in = 64'h1000; step(); rg_pc_en = 0;
    check("first_state", 64'(o_state[0]), 64'd1);
    check("first_cnt", 64'(o_upd[0]), 64'd0);
    pc_upd(64'h1000, 64'h1004);
    check("seq_cnt", 64'(o_upd[0]), 64'd1);
    check("seq_noerr", 64'(o_valid[0]), 64'd0);

    // Bad sequential PC: record appears next cycle, stop-on-error instance stops
    pc_upd(64'h1000, 64'h1008);
    check("bad_valid", 64'(o_valid[0]), 64'd1);
    check("bad_code", 64'(o_code[0]), 64'd1);
    check("bad_pc", o_pc[0], 64'h1000);
    check("bad_errs", 64'(o_errs[0]), 64'd1);
    check("bad_stop", 64'(o_state[0]), 64'd2);
    check("run_nostop", 64'(o_state[1]), 64'd1);
    pc_upd(64'h1004, 64'h2000);
    step();
    check("stopped_errs", 64'(o_errs[0]), 64'd1);
    err_ready = 1; step(); step();

    // Flush outranks the taken prediction
    enter_run(64'h1000);
    flush_valid = 1; flush_pc = 64'h8000_0000; bpu_taken = 1; bpu_target = 64'h2000;
    pc_upd(64'h1000, 64'h8000_0000);
    check("flush_ok", 64'(o_valid[0]), 64'd0);
    pc_upd(64'h1000, 64'h2000);
    check("flush_bad", 64'(o_code[0]), 64'd1);
    idle();
    enter_run(64'h1000);
    bpu_taken = 1; bpu_target = 64'h3000;
    pc_upd(64'h1000, 64'h3000);
    idle();
    pc_upd(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    check("wrap_ok", 64'(o_valid[0]), 64'd0);

    // Epoch toggle checks
    enter_run(64'h1000);
    rg_eepoch = 0; en_update_eepoch = 1; step();
    en_update_eepoch = 0; step();
    check("ee_valid", 64'(o_valid[0]), 64'd1);
    check("ee_code", 64'(o_code[0]), 64'd2);
    enter_run(64'h1000);
    en_update_eepoch = 1; step();
    en_update_eepoch = 0; rg_eepoch = 1; step(); step();
    check("ee_ok", 64'(o_valid[0]), 64'd0);
    rg_wepoch = 1; en_update_wepoch = 1; step();
    en_update_wepoch = 0; step();
    check("we_code", 64'(o_code[0]), 64'd3);

    // Overflow on the free-running instance, then a pop racing a push on a full FIFO
    err_ready = 0;
    enter_run(64'h1000);
    for (int i = 0; i < 9; i++) pc_upd(64'h1000, 64'h1008);
    check("ovf_flag", 64'(o_ovf[1]), 64'd1);
    check("ovf_errs", 64'(o_errs[1]), 64'd9);
    err_ready = 1;
    pc_upd(64'h1000, 64'h1008);
    check("ovf_errs10", 64'(o_errs[1]), 64'd10);
    for (int i = 0; i < 7; i++) step();
    check("full_after7", 64'(o_valid[1]), 64'd1);
    step();
    check("empty_after8", 64'(o_valid[1]), 64'd0);

    // Misaligned target: code 1 wins when the PC is also wrong; code 4 alone otherwise
    enter_run(64'h1000);
    pc_upd(64'h1000, 64'h1005);
    check("mis_code", 64'(o_code[0]), 64'd1);
    check("mis_errs", 64'(o_errs[0]), 64'd1);
    enter_run(64'h1000);
    flush_valid = 1; flush_pc = 64'h1001;
    pc_upd(64'h1000, 64'h1001);
    check("mis_only", 64'(o_code[1]), 64'd4);
    idle(); clear = 1; step(); clear = 0;
    check("clr_state", 64'(o_state[1]), 64'd0);
    check("clr_upd", 64'(o_upd[1]), 64'd0);
    check("clr_valid", 64'(o_valid[1]), 64'd0);

    // Randomized traffic
    cur_pc = 64'h1000; prev_e = 0; prev_w = 0;
    for (int n = 0; n < 2000; n++) begin
      if (prev_e && $urandom_range(0, 9) != 0) rg_eepoch = ~rg_eepoch;
      if (prev_w && $urandom_range(0, 9) != 0) rg_wepoch = ~rg_wepoch;
      clear            = ($urandom_range(0, 63) == 0);
      rg_pc            = cur_pc;
      rg_pc_en         = ($urandom_range(0, 3) != 0);
      flush_valid      = ($urandom_range(0, 7) == 0);
      flush_pc         = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                      : ({$urandom, $urandom} & ~64'h3);
      bpu_taken        = ($urandom_range(0, 5) == 0);
      bpu_target       = {$urandom, $urandom} & ~64'h3;
      en_update_eepoch = ($urandom_range(0, 5) == 0);
      en_update_wepoch = ($urandom_range(0, 5) == 0);
      err_ready        = ($urandom_range(0, 2) != 0);
      legal = flush_valid ? flush_pc : (bpu_taken ? bpu_target : ((cur_pc >> 2) + 64'd1) << 2);
      mode  = $urandom_range(0, 19);
      rg_pc_d_in = (mode == 0) ? {$urandom, $urandom} : (mode == 1) ? (legal | 64'd1) : legal;
      prev_e = en_update_eepoch;
      prev_w = en_update_wepoch;
      step();
      if (rg_pc_en) cur_pc = rg_pc_d_in;
    end

    // Reset while records are pending discards them at once
    idle(); err_ready = 0;
    enter_run(64'h1000);
    pc_upd(64'h1000, 64'h1010);
    do_reset();
    check("rst_mid_valid", 64'(o_valid[1]), 64'd0);
    check("rst_mid_errs", 64'(o_errs[1]), 64'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_trace_checker.md
# fetch_trace_checker

Synthesizable consumer of the stage0 probe stream that the simulation top samples from the fetch stage (PC register update, flush redirect, branch-predictor response, epoch registers). It checks every PC update and epoch toggle against the permitted next-state rules and queues violation records in a small FIFO with a valid/ready drain port. It also keeps update and error counters for the regression harness. It sits beside the core in the test SoC and is driven from the same probe signals the interface captures.

## Interface
- XLEN, 64, PC width
- DEPTH, 8, error FIFO entries (power of 2, ≥2)
- STOP_ON_ERROR, 1, 1 = enter STOPPED after the first recorded error
- CLK  in  1  sole clock, all state on posedge
- RST_N  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous soft clear
- rg_pc  in  XLEN  current stage0 PC
- rg_pc_en  in  1  PC register write enable
- rg_pc_d_in  in  XLEN  PC register next value
- flush_valid  in  1  ma_flush_fl valid
- flush_pc  in  XLEN  flush redirect target
- bpu_taken  in  1  prediction response valid and taken
- bpu_target  in  XLEN  predicted target
- en_update_eepoch  in  1  execute-epoch toggle request
- en_update_wepoch  in  1  writeback-epoch toggle request
- rg_eepoch  in  1  execute epoch register
- rg_wepoch  in  1  writeback epoch register
- err_valid  out  1  FIFO head valid
- err_ready  in  1  consumer pops head when err_valid & err_ready
- err_code  out  3  head code
- err_pc  out  XLEN  head PC
- err_overflow  out  1  sticky: a record was dropped
- error_count  out  16  errors detected, saturates at 16'hFFFF
- pc_update_count  out  32  checked PC updates, wraps
- state  out  2  0 WAIT_FIRST, 1 RUN, 2 STOPPED

## Operation
- States:
  - WAIT_FIRST: first rg_pc_en (reset vector) → RUN; that update is not checked or counted.
  - RUN: all checks active.
  - STOPPED: entered at the edge that records an error when STOP_ON_ERROR=1. No checks, no counting. FIFO still drains. Exit only via clear or reset.
- Legal next PC when rg_pc_en in RUN, in priority order:
  - flush_valid → must equal flush_pc;
  - else bpu_taken → must equal bpu_target;
  - else must equal {rg_pc[XLEN-1:2]+1, 2'b00}; the addition wraps modulo 2^XLEN.
- Codes:
  - 1 = bad next PC
  - 2 = eEpoch not toggled
  - 3 = wEpoch not toggled
  - 4 = rg_pc_d_in[0] set (misaligned); checked on any RUN update, independently of code 1
- Epoch check: en_update_eepoch at cycle t requires rg_eepoch(t+1) == ~rg_eepoch(t). Same rule for wepoch. The request and old value are registered; the check is evaluated at t+1 and only if RUN at both t and t+1.
- Multiple violations in one cycle: one record with the lowest code; error_count +1.
- Record PC: rg_pc of the detecting cycle.
- pc_update_count +1 per RUN cycle with rg_pc_en.
- clear has priority over all other activity. It returns to WAIT_FIRST and zeroes the FIFO, counters, err_overflow and the registered epoch state.

## Timing
- Reset (async assert, sync-to-CLK usage on deassert) values:
  - state = 0
  - err_valid = 0
  - err_code = 0
  - err_pc = 0
  - err_overflow = 0
  - both counters = 0
- Detection in cycle t is written at the posedge ending t. err_valid rises in t+1 if the FIFO was empty: one-cycle latency.
- err_code/err_pc hold stable while err_valid & !err_ready.
- Full FIFO with no pop: the new record is dropped, err_overflow set, error_count still increments.
- Full FIFO with a pop in the same cycle: the push is accepted and occupancy is unchanged.
- Empty FIFO with a push and err_ready: the push is accepted. There is no bypass, so err_valid rises next cycle.
- Reset mid-operation discards all records immediately.

## Test plan
- Reset then rg_pc_en with d_in=0x1000 → state=1, pc_update_count=0. Then pc=0x1000, d_in=0x1004 → count=1, err_valid stays 0.
- RUN, pc=0x1000, d_in=0x1008, no flush/bpu → next cycle err_valid=1, code=1, err_pc=0x1000, error_count=1, state=2 (STOP_ON_ERROR=1).
- flush_valid, flush_pc=0x8000_0000, bpu_taken, bpu_target=0x2000, d_in=0x8000_0000 → no error. Same with d_in=0x2000 → code 1.
- en_update_eepoch with rg_eepoch=0, rg_eepoch=0 next cycle → code 2 one cycle after the failing observation. With rg_eepoch=1 next cycle → no record.
- STOP_ON_ERROR=0, DEPTH=8, err_ready=0, 9 bad updates → 8 records held, err_overflow=1, error_count=9. Then a pop concurrent with a 10th error → occupancy stays 8.
- d_in=0x1005 misaligned in RUN → one record, code 1 (lowest wins), error_count +1. Then assert clear → state=0, counters 0, err_valid=0.
